inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction-fetch stage of the RISC-V core. Sits directly upstream of the immediate generator and decoder.
- Owns the program counter and runs a request/response handshake with instruction memory.
- Presents one fetched instruction word plus its PC and holds it until the downstream stage accepts it.
- Accepts redirects (branch/jump/jalr targets) from execute. Drops any fetch that is in flight when a redirect arrives.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INST, 32'h00000013, value driven on inst when no valid instruction is held (addi x0,x0,0).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  byte address of request; equals internal pc.
imem_ready  input  1  memory accepts request this cycle (when imem_req=1).
imem_rvalid  input  1  response data valid this cycle.
imem_rdata  input  32  instruction word returned by memory.
inst  output  32  held instruction word to immGen/decoder.
pc_out  output  32  address of the held instruction.
inst_valid  output  1  inst/pc_out hold a valid fetched instruction.
inst_ack  input  1  downstream consumes held instruction (effective only when inst_valid=1).
redirect  input  1  load new PC from redirect_target.
redirect_target  input  32  new PC value.
misalign_err  output  1  sticky flag: last redirect target had bits[1:0]!=0.

Behaviour:
- One clock domain. All state changes on the rising edge of clk. Reset is synchronous, active-high. Priority: reset > redirect > normal flow.
- Reset values: pc=RESET_PC, state=REQ, inst=NOP_INST, pc_out=RESET_PC, inst_valid=0, misalign_err=0. imem_req is combinational from state, so it reads 1 in the first cycle after reset deasserts.
- States:
  - REQ: imem_req=1, imem_addr=pc. If imem_ready, move to WAIT. Otherwise stay; request stays asserted.
  - WAIT: imem_req=0. On imem_rvalid: inst<=imem_rdata, pc_out<=pc, inst_valid<=1, move to HOLD.
  - HOLD: imem_req=0; inst/pc_out stable. On inst_ack: pc<=pc+4 (mod 2^32, wraps 0xFFFFFFFC->0), inst_valid<=0, inst<=NOP_INST, move to REQ.
  - DRAIN: imem_req=0. Discards exactly one outstanding response. On imem_rvalid: data ignored, move to REQ.
- Latency:
  - Zero-wait memory (ready in REQ, rvalid on the next cycle): inst_valid rises 2 cycles after entering REQ.
  - Back-to-back throughput with same-cycle ack: one instruction every 3 cycles.
- Redirect with aligned target (target[1:0]==0): pc<=target, misalign_err<=0, then by state:
  - REQ, imem_ready=0: stay REQ. The new address appears next cycle. The address may change while a request is unaccepted; memory must tolerate this.
  - REQ, imem_ready=1: the old request was accepted. Go DRAIN.
  - WAIT, imem_rvalid=0: go DRAIN.
  - WAIT, imem_rvalid=1: discard the data and go REQ. inst_valid stays 0.
  - HOLD: inst_valid<=0, inst<=NOP_INST, go REQ. A simultaneous inst_ack is ignored; no pc+4.
  - DRAIN: stay DRAIN, or go REQ if imem_rvalid this cycle; pc updated either way.
- Redirect with misaligned target: pc and state unchanged, misalign_err<=1. The flag stays 1 until reset or an aligned redirect.
- inst_ack while inst_valid=0 has no effect.
- imem_rvalid in REQ or HOLD is unexpected. It is ignored and no state changes.
- Reset mid-transaction (any state) returns to REQ with pc=RESET_PC. The outstanding memory response is not tracked; the memory model must be reset together with this block.
- pc is always word-aligned. imem_addr[1:0] is always 2'b00.

Test Plan:
- Reset then zero-wait memory returning 32'h66208c23 for addr 0 -> cycle 1 imem_req=1 addr 0; cycle 3 inst_valid=1, inst=32'h66208c23, pc_out=0; ack -> next request at addr 4.
- Memory with imem_ready low for 3 cycles and rvalid delayed 2 cycles, returning 32'ha1204883 -> imem_req held 4 cycles with constant addr; inst_valid only after rvalid; inst stable in HOLD for 5 cycles without ack.
- Sequential fetch of 32'he6208b33, 32'h21204883 at 0x10, 0x14 with ack each time -> pc_out 0x10 then 0x14, no duplicates or skips.
- Redirect to 32'h00000100 while in WAIT with rvalid two cycles later -> stale word discarded (DRAIN), next request addr 0x100, inst_valid never asserted for the stale word.
- Redirect to 32'h00000102 in HOLD -> misalign_err=1, inst/pc_out unchanged, inst_valid stays 1. Then redirect to 0x200 -> misalign_err=0, fetch at 0x200.
- pc at 32'hFFFFFFFC with ack -> next imem_addr=32'h00000000. Assert reset during WAIT -> next cycle state REQ, addr RESET_PC, inst_valid=0, inst=32'h00000013.

Source files
------------

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: instruction-memory handshake, held-instruction output
// toward the decoder, and the redirect path from execute.
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        inst_ack;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, inst, pc_out, inst_valid, misalign_err,
        input  imem_ready, imem_rvalid, imem_rdata, inst_ack, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, inst, pc_out, inst_valid, misalign_err,
        output imem_ready, imem_rvalid, imem_rdata, inst_ack, redirect, redirect_target
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time from
// instruction memory and holds it until the decoder acknowledges it.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset,
    inst_fetch_if.master bus
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] pc_out_q;
    logic        inst_valid_q;
    logic        misalign_q;

    logic [31:0] pc_plus4_d;
    logic        target_aligned_d;

    assign pc_plus4_d       = pc_q + 32'd4;
    assign target_aligned_d = (bus.redirect_target[1:0] == 2'b00);

    assign bus.imem_req     = (state_q == REQ);
    assign bus.imem_addr    = pc_q;
    assign bus.inst         = inst_q;
    assign bus.pc_out       = pc_out_q;
    assign bus.inst_valid   = inst_valid_q;
    assign bus.misalign_err = misalign_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            inst_q       <= NOP_INST;
            pc_out_q     <= RESET_PC;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else if (bus.redirect && !target_aligned_d) begin
            // A misaligned target is rejected outright; everything else freezes.
            misalign_q <= 1'b1;
        end else if (bus.redirect) begin
            pc_q       <= {bus.redirect_target[31:2], 2'b00};
            misalign_q <= 1'b0;
            case (state_q)
                REQ:   if (bus.imem_ready) state_q <= DRAIN;
                WAIT:  state_q <= bus.imem_rvalid ? REQ : DRAIN;
                HOLD: begin
                    inst_valid_q <= 1'b0;
                    inst_q       <= NOP_INST;
                    state_q      <= REQ;
                end
                DRAIN: if (bus.imem_rvalid) state_q <= REQ;
                default: state_q <= REQ;
            endcase
        end else begin
            case (state_q)
                REQ:   if (bus.imem_ready) state_q <= WAIT;
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        inst_q       <= bus.imem_rdata;
                        pc_out_q     <= pc_q;
                        inst_valid_q <= 1'b1;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.inst_ack) begin
                        pc_q         <= pc_plus4_d;
                        inst_valid_q <= 1'b0;
                        inst_q       <= NOP_INST;
                        state_q      <= REQ;
                    end
                end
                // The stale response belongs to a fetch abandoned by a redirect.
                DRAIN: if (bus.imem_rvalid) state_q <= REQ;
                default: state_q <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios followed by a
// randomized run scored against a transaction-level model.
module tb_inst_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory contents as a bijective function of address, so stale data is detectable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_ready      = 1'b0;
        bus.imem_rvalid     = 1'b0;
        bus.imem_rdata      = 32'h0;
        bus.inst_ack        = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
    endtask

    // Zero-wait fetch from REQ; leaves the DUT in HOLD.
    task automatic fetch_word(input logic [31:0] data);
        bus.imem_ready  = 1'b1;
        step();
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        step();
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.pc_out, bus.misalign_err}
            !== {1'b1, RESET_PC, 1'b0, NOP, RESET_PC, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b addr=%h v=%b inst=%h pc=%h mis=%b want 1 %h 0 %h %h 0",
                     bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, bus.pc_out,
                     bus.misalign_err, RESET_PC, NOP, RESET_PC);
        end
        reset = 1'b0;
    endtask

    task automatic test_zero_wait();
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL zw_cycle1: got req=%b addr=%h want 1 00000000", bus.imem_req, bus.imem_addr);
        end
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready  = 1'b0;
        n_cmp++;
        if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL zw_cycle2: got req=%b v=%b want 0 0", bus.imem_req, bus.inst_valid);
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h6620_8c23;
        step();
        bus.imem_rvalid = 1'b0;
        n_cmp++;
        if ({bus.inst_valid, bus.inst, bus.pc_out} !== {1'b1, 32'h6620_8c23, 32'h0}) begin
            n_fail++;
            $display("FAIL zw_cycle3: got v=%b inst=%h pc=%h want 1 66208c23 00000000",
                     bus.inst_valid, bus.inst, bus.pc_out);
        end
        bus.inst_ack = 1'b1;
        step();
        bus.inst_ack = 1'b0;
        n_cmp++;
        if ({bus.inst_valid, bus.imem_req, bus.imem_addr, bus.inst} !== {1'b0, 1'b1, 32'h4, NOP}) begin
            n_fail++;
            $display("FAIL zw_after_ack: got v=%b req=%b addr=%h inst=%h want 0 1 00000004 %h",
                     bus.inst_valid, bus.imem_req, bus.imem_addr, bus.inst, NOP);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = (i == 3);
            n_cmp++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) begin
                n_fail++;
                $display("FAIL ws_req_hold[%0d]: got req=%b addr=%h want 1 00000004",
                         i, bus.imem_req, bus.imem_addr);
            end
            step();
        end
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL ws_wait[%0d]: got req=%b v=%b want 0 0", i, bus.imem_req, bus.inst_valid);
            end
            step();
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'ha120_4883;
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'hffff_ffff;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({bus.inst_valid, bus.inst, bus.pc_out, bus.imem_req} !== {1'b1, 32'ha120_4883, 32'h4, 1'b0}) begin
                n_fail++;
                $display("FAIL ws_hold[%0d]: got v=%b inst=%h pc=%h req=%b want 1 a1204883 00000004 0",
                         i, bus.inst_valid, bus.inst, bus.pc_out, bus.imem_req);
            end
            step();
        end
        bus.inst_ack = 1'b1;
        step();
        bus.inst_ack = 1'b0;
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) begin
            n_fail++;
            $display("FAIL ws_next_addr: got req=%b addr=%h want 1 00000008", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h10;
        step();
        bus.redirect = 1'b0;
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h10}) begin
            n_fail++;
            $display("FAIL seq_redirect_req: got req=%b addr=%h want 1 00000010", bus.imem_req, bus.imem_addr);
        end
        fetch_word(32'he620_8b33);
        n_cmp++;
        if ({bus.inst_valid, bus.inst, bus.pc_out} !== {1'b1, 32'he620_8b33, 32'h10}) begin
            n_fail++;
            $display("FAIL seq_first: got v=%b inst=%h pc=%h want 1 e6208b33 00000010",
                     bus.inst_valid, bus.inst, bus.pc_out);
        end
        bus.inst_ack = 1'b1;
        step();
        bus.inst_ack = 1'b0;
        n_cmp++;
        if (bus.imem_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL seq_addr2: got %h want 00000014", bus.imem_addr);
        end
        fetch_word(32'h2120_4883);
        n_cmp++;
        if ({bus.inst_valid, bus.inst, bus.pc_out} !== {1'b1, 32'h2120_4883, 32'h14}) begin
            n_fail++;
            $display("FAIL seq_second: got v=%b inst=%h pc=%h want 1 21204883 00000014",
                     bus.inst_valid, bus.inst, bus.pc_out);
        end
        bus.inst_ack = 1'b1;
        step();
        bus.inst_ack = 1'b0;
        n_cmp++;
        if (bus.imem_addr !== 32'h18) begin
            n_fail++;
            $display("FAIL seq_addr3: got %h want 00000018", bus.imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready      = 1'b0;
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h100;
        step();
        bus.redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({bus.imem_req, bus.inst_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL rw_drain[%0d]: got req=%b v=%b want 0 0", i, bus.imem_req, bus.inst_valid);
            end
            if (i == 0) step();
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hdead_beef;
        step();
        bus.imem_rvalid = 1'b0;
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst} !== {1'b1, 32'h100, 1'b0, NOP}) begin
            n_fail++;
            $display("FAIL rw_after_drain: got req=%b addr=%h v=%b inst=%h want 1 00000100 0 %h",
                     bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, NOP);
        end
    endtask

    task automatic test_misalign();
        fetch_word(32'h0bad_f00d);
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h102;
        step();
        bus.redirect = 1'b0;
        n_cmp++;
        if ({bus.misalign_err, bus.inst_valid, bus.inst, bus.pc_out} !== {2'b11, 32'h0bad_f00d, 32'h100}) begin
            n_fail++;
            $display("FAIL mis_flag: got mis=%b v=%b inst=%h pc=%h want 1 1 0badf00d 00000100",
                     bus.misalign_err, bus.inst_valid, bus.inst, bus.pc_out);
        end
        step();
        n_cmp++;
        if ({bus.misalign_err, bus.inst_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL mis_sticky: got mis=%b v=%b want 1 1", bus.misalign_err, bus.inst_valid);
        end
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h200;
        step();
        bus.redirect = 1'b0;
        n_cmp++;
        if ({bus.misalign_err, bus.inst_valid, bus.imem_req, bus.imem_addr} !== {3'b001, 32'h200}) begin
            n_fail++;
            $display("FAIL mis_clear: got mis=%b v=%b req=%b addr=%h want 0 0 1 00000200",
                     bus.misalign_err, bus.inst_valid, bus.imem_req, bus.imem_addr);
        end
        fetch_word(32'h1234_5677);
        n_cmp++;
        if ({bus.inst_valid, bus.pc_out, bus.inst} !== {1'b1, 32'h200, 32'h1234_5677}) begin
            n_fail++;
            $display("FAIL mis_fetch: got v=%b pc=%h inst=%h want 1 00000200 12345677",
                     bus.inst_valid, bus.pc_out, bus.inst);
        end
    endtask

    task automatic test_wrap();
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'hffff_fffc;
        step();
        bus.redirect = 1'b0;
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr, bus.inst_valid} !== {1'b1, 32'hffff_fffc, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_req: got req=%b addr=%h v=%b want 1 fffffffc 0",
                     bus.imem_req, bus.imem_addr, bus.inst_valid);
        end
        fetch_word(32'hcafe_0013);
        n_cmp++;
        if (bus.pc_out !== 32'hffff_fffc) begin
            n_fail++;
            $display("FAIL wrap_pc_out: got %h want fffffffc", bus.pc_out);
        end
        bus.inst_ack = 1'b1;
        step();
        bus.inst_ack = 1'b0;
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_addr: got req=%b addr=%h want 1 00000000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_reset_mid();
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h40;
        step();
        bus.redirect   = 1'b0;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst} !== {1'b1, RESET_PC, 1'b0, NOP}) begin
            n_fail++;
            $display("FAIL reset_mid: got req=%b addr=%h v=%b inst=%h want 1 %h 0 %h",
                     bus.imem_req, bus.imem_addr, bus.inst_valid, bus.inst, RESET_PC, NOP);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] mem_addr;
        logic [31:0] tgt;
        logic [31:0] prev_inst;
        logic [31:0] prev_pcout;
        bit          exp_mis;
        bit          mem_busy;
        int          mem_delay;
        bit          prev_valid, prev_consume, prev_redir, prev_reset;
        bit          do_reset, do_ready, do_rvalid, do_ack, do_redir;
        int          deliveries;

        idle_inputs();
        reset = 1'b1;
        step();
        reset        = 1'b0;
        exp_pc       = RESET_PC;
        exp_mis      = 1'b0;
        mem_busy     = 1'b0;
        mem_addr     = 32'h0;
        mem_delay    = 0;
        prev_valid   = 1'b0;
        prev_consume = 1'b0;
        prev_redir   = 1'b0;
        prev_reset   = 1'b1;
        prev_inst    = NOP;
        prev_pcout   = RESET_PC;
        deliveries   = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            n_cmp++;
            if (bus.imem_addr[1:0] !== 2'b00) begin
                n_fail++;
                $display("FAIL rnd_align: cycle %0d got addr=%h want low bits 00", cyc, bus.imem_addr);
            end
            if (bus.imem_req === 1'b1) begin
                n_cmp++;
                if (bus.imem_addr !== exp_pc) begin
                    n_fail++;
                    $display("FAIL rnd_addr: cycle %0d got %h want %h", cyc, bus.imem_addr, exp_pc);
                end
            end
            n_cmp++;
            if (bus.misalign_err !== exp_mis) begin
                n_fail++;
                $display("FAIL rnd_misalign: cycle %0d got %b want %b", cyc, bus.misalign_err, exp_mis);
            end
            if (prev_reset) begin
                n_cmp++;
                if ({bus.inst_valid, bus.inst, bus.pc_out} !== {1'b0, NOP, RESET_PC}) begin
                    n_fail++;
                    $display("FAIL rnd_reset: cycle %0d got v=%b inst=%h pc=%h want 0 %h %h",
                             cyc, bus.inst_valid, bus.inst, bus.pc_out, NOP, RESET_PC);
                end
            end
            if (prev_redir || prev_consume) begin
                n_cmp++;
                if (bus.inst_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_drop: cycle %0d got v=%b want 0", cyc, bus.inst_valid);
                end
            end
            if (bus.inst_valid === 1'b1) begin
                n_cmp++;
                if (bus.inst !== mem_word(bus.pc_out)) begin
                    n_fail++;
                    $display("FAIL rnd_data: cycle %0d pc=%h got %h want %h",
                             cyc, bus.pc_out, bus.inst, mem_word(bus.pc_out));
                end
                n_cmp++;
                if (!prev_valid) begin
                    deliveries++;
                    if (bus.pc_out !== exp_pc) begin
                        n_fail++;
                        $display("FAIL rnd_order: cycle %0d got pc=%h want %h", cyc, bus.pc_out, exp_pc);
                    end
                end else if ({bus.inst, bus.pc_out} !== {prev_inst, prev_pcout}) begin
                    n_fail++;
                    $display("FAIL rnd_hold: cycle %0d got %h@%h want %h@%h",
                             cyc, bus.inst, bus.pc_out, prev_inst, prev_pcout);
                end
            end else begin
                n_cmp++;
                if (bus.inst !== NOP) begin
                    n_fail++;
                    $display("FAIL rnd_nop: cycle %0d got %h want %h", cyc, bus.inst, NOP);
                end
            end

            do_reset  = ($urandom_range(0, 199) == 0);
            do_rvalid = mem_busy && (mem_delay == 0);
            do_ready  = (bus.imem_req === 1'b1) && ($urandom_range(0, 3) != 0);
            do_ack    = ($urandom_range(0, 1) == 1);
            do_redir  = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hffff_fff0 | ($urandom & 32'hc);
                1:       tgt = $urandom & 32'h0000_03fc;
                2:       tgt = $urandom & 32'hffff_fffc;
                default: tgt = ($urandom & 32'h0000_03fc) | 32'($urandom_range(1, 3));
            endcase
            // A rejected redirect freezes the stage, so keep it clear of handshake beats.
            if (tgt[1:0] != 2'b00 && (do_rvalid || do_ready)) tgt[1:0] = 2'b00;
            if (do_redir && tgt[1:0] != 2'b00) do_ack = 1'b0;

            reset               = do_reset;
            bus.imem_ready      = do_ready;
            bus.imem_rvalid     = do_rvalid;
            bus.imem_rdata      = do_rvalid ? mem_word(mem_addr) : $urandom;
            bus.inst_ack        = do_ack;
            bus.redirect        = do_redir;
            bus.redirect_target = tgt;

            prev_valid   = (bus.inst_valid === 1'b1);
            prev_inst    = bus.inst;
            prev_pcout   = bus.pc_out;
            prev_reset   = do_reset;
            prev_redir   = !do_reset && do_redir && (tgt[1:0] == 2'b00);
            prev_consume = !do_reset && !do_redir && do_ack && prev_valid;
            if (do_reset) begin
                exp_pc   = RESET_PC;
                exp_mis  = 1'b0;
                mem_busy = 1'b0;
            end else begin
                if (do_rvalid) mem_busy = 1'b0;
                else if (mem_busy) mem_delay--;
                if (do_ready) begin
                    mem_busy  = 1'b1;
                    mem_addr  = bus.imem_addr;
                    mem_delay = $urandom_range(0, 2);
                end
                if (do_redir) begin
                    if (tgt[1:0] == 2'b00) begin
                        exp_pc  = tgt;
                        exp_mis = 1'b0;
                    end else begin
                        exp_mis = 1'b1;
                    end
                end else if (prev_consume) begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
            step();
        end
        idle_inputs();
        reset = 1'b0;
        n_cmp++;
        if (deliveries < 100) begin
            n_fail++;
            $display("FAIL rnd_progress: got %0d deliveries want at least 100", deliveries);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_sequential();
        test_redirect_wait();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
